uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 32 +++
 rtl/uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//   Write-side handshake bundle for the UART transmitter FIFO.
//
//   Signals:
//     tx_valid  producer -> FIFO   write request for tx_data
//     tx_data   producer -> FIFO   word to transmit (DATA_BITS wide)
//     tx_ready  FIFO -> producer   FIFO can accept a word this cycle
//
//   Modports:
//     master  the producer writing words
//     slave   the uart_tx_fifo accepting words
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with a small transmit FIFO in front of it. Words written
//   through the handshake interface are queued and sent as serial frames:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1). Back-to-back frames are sent with no idle gap
//   while the FIFO holds data.
//
//   Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
//   the data bits (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
//   Without the macro there is no parity state or logic at all.
//
//   Ports:
//     clk         single clock, rising edge
//     reset       asynchronous, active-high reset
//     wr          uart_tx_fifo_if.slave: tx_valid, tx_data in; tx_ready out
//     tx          registered serial line, idle high
//     busy        FIFO non-empty or frame in progress
//     fifo_count  FIFO occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    uart_tx_fifo_if.slave                    wr,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    // Elaboration-time parameter legality checks.
    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be 5..8");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
            $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Transmitter state
    state_t               state_q, state_nx;
    logic [BAUD_W-1:0]    baud_q, baud_nx;
    logic [BIT_W-1:0]     bit_q, bit_nx;
    logic                 tx_q, tx_nx;
    logic [DATA_BITS-1:0] shift_q, shift_nx;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_nx;
`endif

    // Ready depends only on occupancy, never on a same-cycle pop, so the
    // producer never sees a combinational path through the FSM.
    assign wr.tx_ready = (count_q < FULL_CNT);
    assign push        = wr.tx_valid && wr.tx_ready;
    assign head        = mem[rd_ptr_q];

    assign fifo_count  = count_q;
    assign tx          = tx_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);

    // ---- FIFO write side: storage is data only, no reset ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr.tx_data;
        end
    end

    // ---- FIFO pointers and occupancy ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---- FSM state register and control counters ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_nx;
            baud_q  <= baud_nx;
            bit_q   <= bit_nx;
            tx_q    <= tx_nx;
        end
    end

    // ---- Frame data registers: loaded on pop, no reset needed ----
    always_ff @(posedge clk) begin
        shift_q <= shift_nx;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_nx;
`endif
    end

    assign bit_end = (baud_q == BAUD_LAST);

    // ---- FSM next-state and outputs ----
    always_comb begin
        state_nx = state_q;
        baud_nx  = baud_q;
        bit_nx   = bit_q;
        tx_nx    = tx_q;
        shift_nx = shift_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nx   = par_q;
`endif

        // Baud counter free-runs inside a frame and reloads at every bit
        // boundary; it rests at zero while idle.
        if (state_q != IDLE) begin
            baud_nx = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_nx = head;
`ifdef UART_TX_PARITY_EN
                    par_nx   = (^head) ^ 1'(PARITY_ODD);
`endif
                    tx_nx    = 1'b0;
                    baud_nx  = '0;
                    state_nx = START;
                end
            end

            START: begin
                if (bit_end) begin
                    tx_nx    = shift_q[0];
                    shift_nx = shift_q >> 1;
                    bit_nx   = '0;
                    state_nx = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_nx   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_nx    = par_q;
                        state_nx = PARITY;
`else
                        tx_nx    = 1'b1;
                        state_nx = STOP;
`endif
                    end else begin
                        tx_nx    = shift_q[0];
                        shift_nx = shift_q >> 1;
                        bit_nx   = bit_q + BIT_W'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_nx    = 1'b1;
                    bit_nx   = '0;
                    state_nx = STOP;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_nx = '0;
                        // Chain straight into the next start bit when more
                        // data is queued, so consecutive frames have no gap.
                        if (count_q != '0) begin
                            pop      = 1'b1;
                            shift_nx = head;
`ifdef UART_TX_PARITY_EN
                            par_nx   = (^head) ^ 1'(PARITY_ODD);
`endif
                            tx_nx    = 1'b0;
                            state_nx = START;
                        end else begin
                            tx_nx    = 1'b1;
                            state_nx = IDLE;
                        end
                    end else begin
                        bit_nx = bit_q + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
                baud_nx  = '0;
                bit_nx   = '0;
            end
        endcase
    end

endmodule
